// File: rtl/inst_axi_responder.sv
// Instruction-fetch bridge: turns one fetch request (single 4-byte or double
// 8-byte) into an AXI read burst and returns the instruction pair. Only one
// transaction is ever outstanding, so read data is steered by beat count alone.
module inst_axi_responder #(
  parameter logic [3:0] AXI_ID         = 4'd0,
  parameter logic [3:0] CACHED_ARCACHE = 4'b1111
) (
  input  logic        clk,
  input  logic        resetn,
  // fetch side
  input  logic        inst_req,
  input  logic [31:0] inst_addr4,
  input  logic [1:0]  inst_size,
  input  logic        inst_cached,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [63:0] inst_rdata,
  output logic        inst_err,
  // AXI read-address channel
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [3:0]  arcache,
  output logic        arvalid,
  input  logic        arready,
  // AXI read-data channel
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready
);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_RESP} state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;       // fetch address latched on accept
  logic        dbl_q, dbl_d;         // 1: 8-byte double fetch
  logic        cached_q, cached_d;
  logic        cnt_q, cnt_d;         // beat index within the burst
  logic [31:0] word0_q, word0_d;     // first beat, kept until rlast
  logic        berr_q, berr_d;       // any non-OKAY rresp seen so far
  logic [63:0] out_data_q, out_data_d;
  logic        out_err_q, out_err_d;

  // rid carries no information with a single outstanding transaction.
  logic unused_rid;
  assign unused_rid = ^rid;

  // Next-state, datapath updates and handshake outputs.
  always_comb begin
    logic        beat_err;
    logic [31:0] lo_word;
    logic [31:0] hi_word;
    // NOTE: every signal driven here gets a default first, so no path can leave it unassigned and infer a latch.
    state_d      = state_q;
    addr_d       = addr_q;
    dbl_d        = dbl_q;
    cached_d     = cached_q;
    cnt_d        = cnt_q;
    word0_d      = word0_q;
    berr_d       = berr_q;
    out_data_d   = out_data_q;
    out_err_d    = out_err_q;
    inst_addr_ok = 1'b0;
    inst_data_ok = 1'b0;
    arvalid      = 1'b0;
    rready       = 1'b0;
    beat_err     = 1'b0;
    lo_word      = 32'h0;
    hi_word      = 32'h0;

    unique case (state_q)
      S_IDLE: begin
        inst_addr_ok = inst_req;
        if (inst_req) begin
          addr_d   = inst_addr4;
          dbl_d    = (inst_size == 2'b11);
          cached_d = inst_cached;
          cnt_d    = 1'b0;
          berr_d   = 1'b0;
          state_d  = S_ADDR;
        end
      end
      S_ADDR: begin
        arvalid = 1'b1;
        if (arready) state_d = S_DATA;
      end
      S_DATA: begin
        rready = 1'b1;
        if (rvalid) begin
          beat_err = berr_q | (rresp != 2'b00);
          berr_d   = beat_err;
          cnt_d    = cnt_q + 1'b1;
          if (!cnt_q) word0_d = rdata;
          if (rlast) begin
            // Beat 0 may be arriving right now or may already be stored.
            lo_word = cnt_q ? word0_q : rdata;
            if (dbl_q) hi_word = cnt_q ? rdata : 32'h0;
            else       hi_word = lo_word;
            out_data_d = {hi_word, lo_word};
            // A double fetch that ends after one beat is short: flag it.
            out_err_d  = beat_err | (dbl_q & ~cnt_q);
            state_d    = S_RESP;
          end
        end
      end
      S_RESP: begin
        inst_data_ok = 1'b1;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any transaction in flight.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      addr_q     <= 32'h0;
      dbl_q      <= 1'b0;
      cached_q   <= 1'b0;
      cnt_q      <= 1'b0;
      word0_q    <= 32'h0;
      berr_q     <= 1'b0;
      out_data_q <= 64'h0;
      out_err_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values regardless of statement order.
      state_q    <= state_d;
      addr_q     <= addr_d;
      dbl_q      <= dbl_d;
      cached_q   <= cached_d;
      cnt_q      <= cnt_d;
      word0_q    <= word0_d;
      berr_q     <= berr_d;
      out_data_q <= out_data_d;
      out_err_q  <= out_err_d;
    end
  end

  // AR fields come straight from latched request state, so they hold while arvalid waits.
  assign arid       = AXI_ID;
  assign araddr     = dbl_q ? {addr_q[31:3], 3'b000} : addr_q;
  assign arlen      = dbl_q ? 8'd1 : 8'd0;
  assign arsize     = 3'd2;
  assign arburst    = 2'b01;
  assign arcache    = cached_q ? CACHED_ARCACHE : 4'b0000;
  assign inst_rdata = out_data_q;
  assign inst_err   = out_err_q;

endmodule

// File: tb/tb_inst_axi_responder.sv
// Self-checking bench for inst_axi_responder: directed scenarios followed by
// randomized fetches, each checked against expectations computed from the
// request, the beats supplied and the handshake delays chosen.
module tb_inst_axi_responder;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_req;
  logic [31:0] inst_addr4;
  logic [1:0]  inst_size;
  logic        inst_cached;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [63:0] inst_rdata;
  logic        inst_err;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [3:0]  arcache;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  inst_axi_responder #(.AXI_ID(4'd0), .CACHED_ARCACHE(4'b1111)) dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_addr4(inst_addr4), .inst_size(inst_size),
    .inst_cached(inst_cached), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata), .inst_err(inst_err),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arburst(arburst), .arcache(arcache), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid),
    .rready(rready)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded its time limit");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
    cycle++;
  endtask

  // Keep a live request with junk fields on the fetch port; it must be ignored.
  task automatic scramble();
    inst_req    = 1'b1;
    inst_addr4  = $urandom;
    inst_size   = 2'($urandom);
    inst_cached = 1'($urandom);
  endtask

  // One complete fetch, started in an IDLE cycle; ends in the IDLE cycle after data_ok.
  task automatic do_txn(input string tag, input logic [31:0] addr, input logic dbl,
                        input logic cached, input int ard, input logic short_b,
                        input logic [31:0] w0, input logic [31:0] w1,
                        input logic [1:0] r0, input logic [1:0] r1,
                        input int g0, input int g1);
    logic [31:0] e_araddr;
    logic [7:0]  e_arlen;
    logic [3:0]  e_arcache;
    logic [63:0] e_data;
    logic        e_err;
    logic        two;
    int          nbeats;
    int          t0;
    int          e_done;
    int          g;

    two       = dbl && !short_b;
    nbeats    = two ? 2 : 1;
    e_araddr  = dbl ? (addr & 32'hFFFF_FFF8) : addr;
    e_arlen   = dbl ? 8'd1 : 8'd0;
    e_arcache = cached ? 4'b1111 : 4'b0000;
    if (!dbl)        e_data = {w0, w0};
    else if (short_b) e_data = {32'h0, w0};
    else             e_data = {w1, w0};
    e_err = (r0 != 2'b00) || (two && (r1 != 2'b00)) || short_b;

    inst_req    = 1'b1;
    inst_addr4  = addr;
    inst_size   = dbl ? 2'b11 : 2'b10;
    inst_cached = cached;
    #1;
    check({tag, ".accept"}, 64'(inst_addr_ok), 64'd1);
    t0     = cycle;
    e_done = t0 + 3 + ard + g0 + (two ? 1 + g1 : 0);
    tick();
    scramble();

    for (int i = 0; i <= ard; i++) begin
      arready = (i == ard);
      #1;
      check({tag, ".arvalid"},  64'(arvalid),      64'd1);
      check({tag, ".araddr"},   64'(araddr),       64'(e_araddr));
      check({tag, ".arlen"},    64'(arlen),        64'(e_arlen));
      check({tag, ".arsize"},   64'(arsize),       64'd2);
      check({tag, ".arburst"},  64'(arburst),      64'd1);
      check({tag, ".arcache"},  64'(arcache),      64'(e_arcache));
      check({tag, ".arid"},     64'(arid),         64'd0);
      check({tag, ".ar_busy"},  64'(inst_addr_ok), 64'd0);
      check({tag, ".ar_rrdy"},  64'(rready),       64'd0);
      check({tag, ".ar_dok"},   64'(inst_data_ok), 64'd0);
      tick();
      scramble();
    end
    arready = 1'b0;

    for (int b = 0; b < nbeats; b++) begin
      g = (b == 0) ? g0 : g1;
      for (int i = 0; i < g; i++) begin
        rvalid = 1'b0;
        rdata  = $urandom;
        #1;
        check({tag, ".gap_rready"}, 64'(rready),       64'd1);
        check({tag, ".gap_busy"},   64'(inst_addr_ok), 64'd0);
        check({tag, ".gap_dok"},    64'(inst_data_ok), 64'd0);
        check({tag, ".gap_arv"},    64'(arvalid),      64'd0);
        tick();
        scramble();
      end
      rvalid = 1'b1;
      rdata  = (b == 0) ? w0 : w1;
      rresp  = (b == 0) ? r0 : r1;
      rlast  = (b == nbeats - 1);
      rid    = 4'($urandom);
      #1;
      check({tag, ".beat_rready"}, 64'(rready),       64'd1);
      check({tag, ".beat_dok"},    64'(inst_data_ok), 64'd0);
      tick();
      scramble();
    end
    rvalid = 1'b0;
    rlast  = 1'b0;
    rdata  = $urandom;
    rresp  = 2'($urandom);
    #1;
    check({tag, ".data_ok"},    64'(inst_data_ok), 64'd1);
    check({tag, ".done_cycle"}, 64'(cycle),        64'(e_done));
    check({tag, ".rdata"},      inst_rdata,        e_data);
    check({tag, ".err"},        64'(inst_err),     64'(e_err));
    check({tag, ".resp_busy"},  64'(inst_addr_ok), 64'd0);
    check({tag, ".resp_rrdy"},  64'(rready),       64'd0);
    tick();
    scramble();
    #1;
    check({tag, ".dok_pulse"},  64'(inst_data_ok), 64'd0);
    check({tag, ".held_data"},  inst_rdata,        e_data);
    check({tag, ".held_err"},   64'(inst_err),     64'(e_err));
    check({tag, ".idle_accept"}, 64'(inst_addr_ok), 64'd1);
  endtask

  initial begin
    logic [31:0] ra, rw0, rw1;
    logic        rdbl, rc, rshort;
    logic [1:0]  rr0, rr1;
    int          rard, rg0, rg1;

    resetn      = 1'b0;
    inst_req    = 1'b0;
    inst_addr4  = 32'h0;
    inst_size   = 2'b10;
    inst_cached = 1'b0;
    arready     = 1'b0;
    rid         = 4'h0;
    rdata       = 32'h0;
    rresp       = 2'b00;
    rlast       = 1'b0;
    rvalid      = 1'b0;
    #2;
    check("rst.arvalid", 64'(arvalid),      64'd0);
    check("rst.rready",  64'(rready),       64'd0);
    check("rst.data_ok", 64'(inst_data_ok), 64'd0);
    check("rst.err",     64'(inst_err),     64'd0);
    check("rst.rdata",   inst_rdata,        64'h0);
    #1;
    resetn = 1'b1;

    // Directed cases.
    do_txn("cached_double", 32'h1FC0_0004, 1'b1, 1'b1, 0, 1'b0,
           32'h1111_1111, 32'h2222_2222, 2'b00, 2'b00, 0, 0);
    do_txn("uncached_single", 32'h1FC0_0004, 1'b0, 1'b0, 0, 1'b0,
           32'hDEAD_BEEF, 32'h0, 2'b00, 2'b00, 0, 0);
    do_txn("arready_stall", 32'h8000_1230, 1'b1, 1'b1, 5, 1'b0,
           32'hA5A5_0001, 32'h5A5A_0002, 2'b00, 2'b00, 0, 0);
    do_txn("slverr_beat0", 32'h0000_0100, 1'b1, 1'b0, 0, 1'b0,
           32'hCAFE_0000, 32'hCAFE_0001, 2'b10, 2'b00, 0, 0);
    do_txn("short_double", 32'h0000_0208, 1'b1, 1'b1, 1, 1'b1,
           32'h1234_5678, 32'h0, 2'b00, 2'b00, 1, 0);

    // Randomized fetches.
    for (int n = 0; n < 40; n++) begin
      ra     = $urandom;
      rdbl   = 1'($urandom);
      rc     = 1'($urandom);
      rard   = $urandom_range(0, 3);
      rshort = rdbl && ($urandom_range(0, 3) == 0);
      rw0    = $urandom;
      rw1    = $urandom;
      rr0    = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
      rr1    = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
      rg0    = $urandom_range(0, 2);
      rg1    = $urandom_range(0, 2);
      do_txn("rand", ra, rdbl, rc, rard, rshort, rw0, rw1, rr0, rr1, rg0, rg1);
    end

    // Reset while in DATA abandons the fetch; a fresh one then completes.
    inst_req    = 1'b1;
    inst_addr4  = 32'h4000_0010;
    inst_size   = 2'b11;
    inst_cached = 1'b1;
    #1;
    check("mid_rst.accept", 64'(inst_addr_ok), 64'd1);
    tick();
    arready = 1'b1;
    tick();
    arready = 1'b0;
    rvalid  = 1'b0;
    #1;
    check("mid_rst.in_data", 64'(rready), 64'd1);
    resetn = 1'b0;
    #1;
    check("mid_rst.arvalid", 64'(arvalid),      64'd0);
    check("mid_rst.rready",  64'(rready),       64'd0);
    check("mid_rst.data_ok", 64'(inst_data_ok), 64'd0);
    check("mid_rst.rdata",   inst_rdata,        64'h0);
    check("mid_rst.err",     64'(inst_err),     64'd0);
    check("mid_rst.idle",    64'(inst_addr_ok), 64'd1);
    resetn = 1'b1;
    do_txn("after_rst", 32'h4000_0014, 1'b1, 1'b1, 0, 1'b0,
           32'h0BAD_F00D, 32'hFEED_FACE, 2'b00, 2'b00, 0, 0);

    inst_req = 1'b0;
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
